id_rm_stage: RTL and testbench
==============================

// Module: id_rm_stage
// PURPOSE
//  Registered R/M-type decode stage for the RV32IM core: decodes OP (0110011) instructions,
//  drives the regfile read ports, selects operands with N-channel writeback forwarding and
//  holds the result in a one-entry output register under a valid/ready handshake toward EX.
//  Successor to the combinational R-type decoder: parametrised width, forwarding, stall, flush, illegal detect.
// PARAMETERS
//  XLEN     32  operand/data width
//  RADDR_W  5   register address width
//  FWD_CH   2   number of forwarding channels; channel 0 = highest priority (youngest)
// PORTS
//  clk           in   1               core clock
//  rst           in   1               synchronous, active-high reset
//  flush_i       in   1               drop held and incoming instruction (branch redirect)
//  inst_i        in   32              instruction from IF
//  inst_valid_i  in   1               inst_i valid
//  inst_ready_o  out  1               stage can accept inst_i this cycle
//  reg1_raddr_o  out  RADDR_W         regfile port 1 address (combinational from inst_i)
//  reg2_raddr_o  out  RADDR_W         regfile port 2 address
//  reg1_re_o     out  1               port 1 read enable
//  reg2_re_o     out  1               port 2 read enable
//  reg1_rdata_i  in   XLEN            port 1 data (same cycle)
//  reg2_rdata_i  in   XLEN            port 2 data (same cycle)
//  fwd_we_i      in   FWD_CH          forwarding channel write enables
//  fwd_waddr_i   in   FWD_CH*RADDR_W  forwarding dest addresses, ch k at [k*RADDR_W +: RADDR_W]
//  fwd_wdata_i   in   FWD_CH*XLEN     forwarding data, ch k at [k*XLEN +: XLEN]
//  out_valid_o   out  1               output register holds a decoded instruction
//  out_ready_i   in   1               EX consumes output this cycle
//  op1_o, op2_o  out  XLEN            registered operands
//  reg_we_o      out  1               registered rd write enable
//  reg_waddr_o   out  RADDR_W         registered rd
//  alu_op_o      out  4               {is_m, funct3}; for non-M: {funct7[5], funct3}
//  is_m_o        out  1               M-extension instruction
//  illegal_o     out  1               OP-opcode with unsupported funct7/funct3 combination
// BEHAVIOUR
//  - Reset: out_valid_o, op1_o, op2_o, reg_we_o, reg_waddr_o, alu_op_o, is_m_o, illegal_o = 0.
//  - inst_ready_o = !out_valid_o | out_ready_i (combinational; high during reset cycle is don't-care,
//    nothing accepted while rst=1). Accept = inst_valid_i & inst_ready_o & !flush_i & !rst.
//  - Read ports: when inst_valid_i and opcode==0110011: raddr = rs1/rs2, re = 1; else addr 0, re 0.
//  - Decode: funct7 0000000 -> legal R (all funct3); 0100000 -> legal only for funct3 000 (SUB), 101 (SRA);
//    0000001 -> legal M (is_m=1); any other funct7 or illegal combo -> illegal_o=1, reg_we_o=0, ops 0.
//  - Non-OP opcode accepted: out_valid_o=1 with reg_we_o=0, illegal_o=0, operands/fields 0 (bubble).
//  - Operand select per source: rs==0 -> 0; else lowest k with fwd_we_i[k] & fwd_waddr k==rs -> fwd data k;
//    else regfile data. Channels with waddr 0 never match.
//  - Latency 1: operands captured at accept edge; output stable while out_valid_o & !out_ready_i (stall).
//  - Output update each edge: accept -> load new; else out_ready_i -> out_valid_o=0; else hold.
//  - Simultaneous consume and accept: new instruction loaded, no bubble (full throughput).
//  - flush_i: next edge out_valid_o=0, incoming instruction dropped, regardless of out_ready_i.
//  - rst mid-stall: output cleared next edge, held instruction lost.
//  - reg_waddr_o = rd even if rd==0; reg_we_o = 1 for legal R/M (writeback ignores x0).
// TESTING
//  1 ADD x3,x1,x2 (0x002081B3), rf x1=5 x2=7, out_ready=1 -> next cycle valid, op1=5 op2=7 we=1 waddr=3 alu_op=0000.
//  2 SUB 0x402081B3 with fwd ch1 x1=0x10 and ch0 x1=0x20 -> op1=0x20 (ch0 wins), alu_op=1000.
//  3 MUL 0x022081B3 issued with out_ready=0 for 3 cycles -> is_m=1, outputs stable, inst_ready_o=0, next inst stalls.
//  4 funct7=0100000 funct3=001 (0x402091B3) -> illegal_o=1, reg_we_o=0; funct7=0x7F -> illegal_o=1.
//  5 back-to-back ADD stream with out_ready=1 -> one result per cycle; flush_i on cycle 3 -> that slot absent.
//  6 source x0 with fwd ch0 waddr=0 data=0xFFFF -> operand 0; rst asserted while stalled -> out_valid_o=0 next edge.

Source files
------------

// File: rtl/id_rm_stage.sv
// id_rm_stage: registered R/M-type (OP opcode 0110011) decode stage for the RV32IM core.
//   Decodes inst_i, drives the two regfile read ports, picks each source operand from the
//   regfile or from the FWD_CH writeback forwarding channels, and holds the decoded result
//   in a one-entry output register with a valid/ready handshake toward EX.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  drop held and incoming instruction
//   inst_i/inst_valid_i      instruction from IF; inst_ready_o = stage can accept
//   reg{1,2}_raddr_o/_re_o   regfile read address/enable (combinational from inst_i)
//   reg{1,2}_rdata_i         regfile read data (same cycle)
//   fwd_we_i/waddr_i/wdata_i forwarding channels, channel 0 = youngest = highest priority
//   out_valid_o/out_ready_i  output handshake toward EX
//   op1_o, op2_o, reg_we_o, reg_waddr_o, alu_op_o, is_m_o, illegal_o  registered decode

// Per-source operand select: x0 reads as zero, otherwise the lowest-numbered forwarding
// channel hitting rs wins, otherwise regfile data.
module id_rm_opsel #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_CH  = 2
) (
  input  logic [RADDR_W-1:0]        rs,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [FWD_CH-1:0]         fwd_we,
  input  logic [FWD_CH*RADDR_W-1:0] fwd_waddr,
  input  logic [FWD_CH*XLEN-1:0]    fwd_wdata,
  output logic [XLEN-1:0]           op
);
  always_comb begin
    op = rf_data;
    // walk from oldest to youngest so the youngest hit overrides
    for (int k = FWD_CH - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_waddr[k*RADDR_W +: RADDR_W] == rs))
        op = fwd_wdata[k*XLEN +: XLEN];
    end
    // also masks channels writing x0, which can only match rs == 0
    if (rs == '0) op = '0;
  end
endmodule

module id_rm_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_CH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [31:0]               inst_i,
  input  logic                      inst_valid_i,
  output logic                      inst_ready_o,
  output logic [RADDR_W-1:0]        reg1_raddr_o,
  output logic [RADDR_W-1:0]        reg2_raddr_o,
  output logic                      reg1_re_o,
  output logic                      reg2_re_o,
  input  logic [XLEN-1:0]           reg1_rdata_i,
  input  logic [XLEN-1:0]           reg2_rdata_i,
  input  logic [FWD_CH-1:0]         fwd_we_i,
  input  logic [FWD_CH*RADDR_W-1:0] fwd_waddr_i,
  input  logic [FWD_CH*XLEN-1:0]    fwd_wdata_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [XLEN-1:0]           op1_o,
  output logic [XLEN-1:0]           op2_o,
  output logic                      reg_we_o,
  output logic [RADDR_W-1:0]        reg_waddr_o,
  output logic [3:0]                alu_op_o,
  output logic                      is_m_o,
  output logic                      illegal_o
);
  localparam logic [6:0] OPC_OP = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic               we;
    logic [RADDR_W-1:0] waddr;
    logic [3:0]         alu_op;
    logic               is_m;
    logic               illegal;
  } dec_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_op, is_m, legal, accept;
  logic [1:0][RADDR_W-1:0] rs_vec;
  logic [1:0][XLEN-1:0]    rf_vec, op_vec;
  dec_t dec_d, out_q;
  logic vld_q;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign is_op  = (opcode == OPC_OP);

  assign rs_vec[0] = RADDR_W'(inst_i[19:15]);
  assign rs_vec[1] = RADDR_W'(inst_i[24:20]);
  assign rf_vec[0] = reg1_rdata_i;
  assign rf_vec[1] = reg2_rdata_i;

  // read ports only track a valid OP instruction; anything else parks them at x0
  assign reg1_re_o    = inst_valid_i & is_op;
  assign reg2_re_o    = inst_valid_i & is_op;
  assign reg1_raddr_o = reg1_re_o ? rs_vec[0] : '0;
  assign reg2_raddr_o = reg2_re_o ? rs_vec[1] : '0;

  for (genvar s = 0; s < 2; s++) begin : g_src
    id_rm_opsel #(.XLEN(XLEN), .RADDR_W(RADDR_W), .FWD_CH(FWD_CH)) u_opsel (
      .rs        (rs_vec[s]),
      .rf_data   (rf_vec[s]),
      .fwd_we    (fwd_we_i),
      .fwd_waddr (fwd_waddr_i),
      .fwd_wdata (fwd_wdata_i),
      .op        (op_vec[s])
    );
  end

  assign is_m  = (funct7 == 7'b0000001);
  assign legal = (funct7 == 7'b0000000) | is_m |
                 ((funct7 == 7'b0100000) & ((funct3 == 3'b000) | (funct3 == 3'b101)));

  // illegal OP and non-OP opcodes both produce an all-zero payload; only the flag differs
  always_comb begin
    dec_d = '0;
    if (is_op) begin
      if (legal) begin
        dec_d.op1    = op_vec[0];
        dec_d.op2    = op_vec[1];
        dec_d.we     = 1'b1;
        dec_d.waddr  = RADDR_W'(inst_i[11:7]);
        dec_d.alu_op = {is_m | funct7[5], funct3};
        dec_d.is_m   = is_m;
      end else begin
        dec_d.illegal = 1'b1;
      end
    end
  end

  assign inst_ready_o = !vld_q | out_ready_i;
  assign accept       = inst_valid_i & inst_ready_o & !flush_i & !rst;

  // payload only changes on accept, so it stays stable across a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      out_q <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      out_q <= dec_d;
    end else if (out_ready_i) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid_o = vld_q;
  assign op1_o       = out_q.op1;
  assign op2_o       = out_q.op2;
  assign reg_we_o    = out_q.we;
  assign reg_waddr_o = out_q.waddr;
  assign alu_op_o    = out_q.alu_op;
  assign is_m_o      = out_q.is_m;
  assign illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_id_rm_stage.sv
module tb_id_rm_stage;
  logic        clk = 1'b0;
  logic        rst, flush_i, inst_valid_i, out_ready_i;
  logic [31:0] inst_i;
  logic        inst_ready_o, reg1_re_o, reg2_re_o;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i;
  logic [1:0]  fwd_we_i;
  logic [9:0]  fwd_waddr_i;
  logic [63:0] fwd_wdata_i;
  logic        out_valid_o, reg_we_o, is_m_o, illegal_o;
  logic [31:0] op1_o, op2_o;
  logic [4:0]  reg_waddr_o;
  logic [3:0]  alu_op_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  // regfile model: x1=5, x2=7, others distinct
  always_comb begin
    reg1_rdata_i = rf[reg1_raddr_o];
    reg2_rdata_i = rf[reg2_raddr_o];
  end

  id_rm_stage #(.XLEN(32), .RADDR_W(5), .FWD_CH(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_i(inst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .op1_o(op1_o), .op2_o(op2_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .alu_op_o(alu_op_o), .is_m_o(is_m_o), .illegal_o(illegal_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  fwe;
    logic [9:0]  fwa;
    logic [63:0] fwd;
    logic        re;
    logic [4:0]  ra1, ra2;
    logic [31:0] op1, op2;
    logic        we;
    logic [4:0]  wa;
    logic [3:0]  alu;
    logic        m, ill;
  } vec_t;

  vec_t vt[12];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'h0; rf[1] = 32'd5; rf[2] = 32'd7;

    //         inst          fwe    fwa              fwd                      re ra1 ra2 op1       op2        we wa alu  m  ill
    vt[0]  = '{32'h002081B3, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd5,    32'd7,     1, 3, 4'h0, 0, 0}; // ADD
    vt[1]  = '{32'h402081B3, 2'b11, {5'd1, 5'd1},    {32'h10, 32'h20},        1, 1,  2,  32'h20,   32'd7,     1, 3, 4'h8, 0, 0}; // SUB, ch0 wins
    vt[2]  = '{32'h022081B3, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd5,    32'd7,     1, 3, 4'h8, 1, 0}; // MUL
    vt[3]  = '{32'h402091B3, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd0,    32'd0,     0, 0, 4'h0, 0, 1}; // f7=20 f3=001
    vt[4]  = '{32'hFE2081B3, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd0,    32'd0,     0, 0, 4'h0, 0, 1}; // f7=7F
    vt[5]  = '{32'h002001B3, 2'b01, {5'd0, 5'd0},    {32'h0, 32'hFFFF},       1, 0,  2,  32'd0,    32'd7,     1, 3, 4'h0, 0, 0}; // rs1=x0, ch0 waddr 0
    vt[6]  = '{32'h002081B3, 2'b10, {5'd2, 5'd2},    {32'hABCD, 32'h1234},    1, 1,  2,  32'd5,    32'hABCD,  1, 3, 4'h0, 0, 0}; // ch1 only enabled
    vt[7]  = '{32'h00108093, 2'b00, 10'd0,           64'd0,                   0, 0,  0,  32'd0,    32'd0,     0, 0, 4'h0, 0, 0}; // ADDI -> bubble
    vt[8]  = '{32'h4020D1B3, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd5,    32'd7,     1, 3, 4'hD, 0, 0}; // SRA
    vt[9]  = '{32'h0220D1B3, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd5,    32'd7,     1, 3, 4'hD, 1, 0}; // DIVU
    vt[10] = '{32'h00208033, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd5,    32'd7,     1, 0, 4'h0, 0, 0}; // rd=x0
    vt[11] = '{32'h0020E1B3, 2'b00, 10'd0,           64'd0,                   1, 1,  2,  32'd5,    32'd7,     1, 3, 4'h6, 0, 0}; // OR

    rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; out_ready_i = 1'b1;
    inst_i = 32'h0; fwd_we_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid", out_valid_o, 0);
    chk("rst op1", op1_o, 0);
    chk("rst op2", op2_o, 0);
    chk("rst we", reg_we_o, 0);
    chk("rst waddr", reg_waddr_o, 0);
    chk("rst alu", alu_op_o, 0);
    chk("rst m", is_m_o, 0);
    chk("rst ill", illegal_o, 0);
    rst = 1'b0;

    // table vectors, back to back with out_ready=1
    for (int i = 0; i < 12; i++) begin
      inst_i = vt[i].inst; inst_valid_i = 1'b1;
      fwd_we_i = vt[i].fwe; fwd_waddr_i = vt[i].fwa; fwd_wdata_i = vt[i].fwd;
      #1;
      chk($sformatf("v%0d re1", i), reg1_re_o, vt[i].re);
      chk($sformatf("v%0d re2", i), reg2_re_o, vt[i].re);
      chk($sformatf("v%0d ra1", i), reg1_raddr_o, vt[i].ra1);
      chk($sformatf("v%0d ra2", i), reg2_raddr_o, vt[i].ra2);
      chk($sformatf("v%0d ready", i), inst_ready_o, 1);
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d valid", i), out_valid_o, 1);
      chk($sformatf("v%0d op1", i), op1_o, vt[i].op1);
      chk($sformatf("v%0d op2", i), op2_o, vt[i].op2);
      chk($sformatf("v%0d we", i), reg_we_o, vt[i].we);
      chk($sformatf("v%0d waddr", i), reg_waddr_o, vt[i].wa);
      chk($sformatf("v%0d alu", i), alu_op_o, vt[i].alu);
      chk($sformatf("v%0d m", i), is_m_o, vt[i].m);
      chk($sformatf("v%0d ill", i), illegal_o, vt[i].ill);
    end
    inst_valid_i = 1'b0; fwd_we_i = '0;
    @(posedge clk); @(negedge clk);
    chk("drain valid", out_valid_o, 0);

    // stall: MUL held for 3 cycles while the next ADD waits
    inst_i = 32'h022081B3; inst_valid_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk); @(negedge clk);
    inst_i = 32'h00108233; // ADD x4,x1,x1
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("stall%0d valid", j), out_valid_o, 1);
      chk($sformatf("stall%0d m", j), is_m_o, 1);
      chk($sformatf("stall%0d op1", j), op1_o, 5);
      chk($sformatf("stall%0d waddr", j), reg_waddr_o, 3);
      chk($sformatf("stall%0d ready", j), inst_ready_o, 0);
      @(posedge clk); @(negedge clk);
    end
    out_ready_i = 1'b1; #1;
    chk("unstall ready", inst_ready_o, 1);
    @(posedge clk); @(negedge clk);
    chk("next valid", out_valid_o, 1);
    chk("next m", is_m_o, 0);
    chk("next waddr", reg_waddr_o, 4);
    chk("next op2", op2_o, 5);

    // flush while stalled drops the held instruction
    inst_valid_i = 1'b0; out_ready_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("hold valid", out_valid_o, 1);
    flush_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("flush stall valid", out_valid_o, 0);
    flush_i = 1'b0;

    // stream of ADDs rd=5..8, flush during the third slot
    out_ready_i = 1'b1; inst_valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      inst_i = 32'h00208033 | (32'(5 + c) << 7);
      flush_i = (c == 2);
      @(posedge clk); @(negedge clk);
      chk($sformatf("stream%0d valid", c), out_valid_o, (c != 2));
      if (c != 2) chk($sformatf("stream%0d waddr", c), reg_waddr_o, 5 + c);
    end
    flush_i = 1'b0; inst_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("stream drain", out_valid_o, 0);

    // reset mid-stall loses the held instruction
    inst_i = 32'h002081B3; inst_valid_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre-rst valid", out_valid_o, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid-rst valid", out_valid_o, 0);
    chk("mid-rst op1", op1_o, 0);
    chk("mid-rst waddr", reg_waddr_o, 0);
    rst = 1'b0; inst_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post-rst valid", out_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
